// File: rtl/osd_char_render_if.sv
// Signal bundle for the OSD character renderer: video in/out, text buffer and character ROM.
// The renderer uses the slave modport; the video source and memories use master.
interface osd_char_render_if #(
    parameter int unsigned PIX_W   = 24,
    parameter int unsigned TEXT_AW = 5,
    parameter int unsigned ROM_AW  = 11
);
    logic               osd_en;
    logic               vs_in;
    logic               hs_in;
    logic               de_in;
    logic [PIX_W-1:0]   pix_in;
    logic [TEXT_AW-1:0] text_addr;
    logic [7:0]         text_data;
    logic [ROM_AW-1:0]  rom_addr;
    logic               rom_rd_en;
    logic [7:0]         rom_data;
    logic               vs_out;
    logic               hs_out;
    logic               de_out;
    logic [PIX_W-1:0]   pix_out;

    modport master (
        output osd_en, vs_in, hs_in, de_in, pix_in, text_data, rom_data,
        input  text_addr, rom_addr, rom_rd_en, vs_out, hs_out, de_out, pix_out
    );

    modport slave (
        input  osd_en, vs_in, hs_in, de_in, pix_in, text_data, rom_data,
        output text_addr, rom_addr, rom_rd_en, vs_out, hs_out, de_out, pix_out
    );
endinterface

// File: rtl/osd_char_render.sv
// Text overlay renderer: maps raster position to an 8x16 text cell, fetches code and glyph row,
// and composites the glyph over the passing video with a fixed 5-clock latency.
module osd_char_render #(
    parameter int unsigned      PIX_W    = 24,
    parameter int unsigned      H_START  = 16,
    parameter int unsigned      V_START  = 16,
    parameter int unsigned      COLS     = 16,
    parameter int unsigned      ROWS     = 2,
    parameter int unsigned      TEXT_AW  = 5,
    parameter int unsigned      ROM_AW   = 11,
    parameter logic [PIX_W-1:0] FG_COLOR = 24'hFFFFFF,
    parameter bit               BG_EN    = 1'b0,
    parameter logic [PIX_W-1:0] BG_COLOR = 24'h000000
) (
    input logic              clk,
    input logic              rst,
    osd_char_render_if.slave osd_io
);

    localparam int unsigned WIN_W = COLS * 8;
    localparam int unsigned WIN_H = ROWS * 16;

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic             win;
        logic             hit;
        logic [2:0]       bit_idx;
        logic [3:0]       glyph_row;
        logic [PIX_W-1:0] pix;
    } side_t;

    logic [11:0]        x_cnt_q, x_cnt_d;
    logic [10:0]        y_cnt_q, y_cnt_d;
    logic               vs_prev_q, de_prev_q;
    logic               frame_ok_q, frame_ok_d;
    logic               osd_en_lat_q, osd_en_lat_d;
    logic               vs_rise, de_fall;
    logic [11:0]        dx;
    logic [10:0]        dy;
    logic               in_win;
    logic [TEXT_AW-1:0] text_addr_q, text_addr_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_rd_en_q;
    side_t              s0;
    side_t              s1_q, s2_q, s3_q, s4_q;
    logic               vs_out_q, hs_out_q, de_out_q;
    logic [PIX_W-1:0]   pix_out_q, pix_out_d;
    logic               glyph_bit;
    logic               unused_bits;

    always_comb begin
        vs_rise = osd_io.vs_in & ~vs_prev_q;
        de_fall = de_prev_q & ~osd_io.de_in;

        x_cnt_d = '0;
        if (osd_io.de_in) begin
            x_cnt_d = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + 12'd1;
        end
        // Frame clear wins over the line increment when both land in one cycle.
        y_cnt_d = y_cnt_q;
        if (vs_rise) begin
            y_cnt_d = '0;
        end else if (de_fall && (y_cnt_q != '1)) begin
            y_cnt_d = y_cnt_q + 11'd1;
        end

        frame_ok_d   = frame_ok_q | vs_rise;
        osd_en_lat_d = vs_rise ? osd_io.osd_en : osd_en_lat_q;

        dx     = x_cnt_q - 12'(H_START);
        dy     = y_cnt_q - 11'(V_START);
        in_win = osd_io.de_in && (x_cnt_q >= 12'(H_START)) && (32'(dx) < WIN_W) &&
                 (y_cnt_q >= 11'(V_START)) && (32'(dy) < WIN_H);

        s0.vs        = osd_io.vs_in;
        s0.hs        = osd_io.hs_in;
        s0.de        = osd_io.de_in;
        s0.win       = in_win;
        s0.hit       = in_win & frame_ok_q & osd_en_lat_q;
        s0.bit_idx   = dx[2:0];
        s0.glyph_row = dy[3:0];
        s0.pix       = osd_io.pix_in;

        text_addr_d = text_addr_q;
        if (in_win) begin
            text_addr_d = TEXT_AW'(32'(dy >> 4) * COLS + 32'(dx >> 3));
        end

        rom_addr_d = rom_addr_q;
        if (s2_q.win) begin
            rom_addr_d = ROM_AW'({osd_io.text_data[6:0], s2_q.glyph_row});
        end

        // Bit 7 of the glyph row is the leftmost pixel of the cell.
        glyph_bit = osd_io.rom_data[~s4_q.bit_idx];
        pix_out_d = s4_q.pix;
        if (s4_q.hit) begin
            if (glyph_bit) begin
                pix_out_d = FG_COLOR;
            end else if (BG_EN) begin
                pix_out_d = BG_COLOR;
            end
        end
    end

    assign unused_bits = ^{osd_io.text_data[7], s4_q.win, s4_q.glyph_row};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            vs_prev_q    <= 1'b0;
            de_prev_q    <= 1'b0;
            frame_ok_q   <= 1'b0;
            osd_en_lat_q <= 1'b0;
            text_addr_q  <= '0;
            rom_addr_q   <= '0;
            rom_rd_en_q  <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            s4_q         <= '0;
            vs_out_q     <= 1'b0;
            hs_out_q     <= 1'b0;
            de_out_q     <= 1'b0;
            pix_out_q    <= '0;
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            vs_prev_q    <= osd_io.vs_in;
            de_prev_q    <= osd_io.de_in;
            frame_ok_q   <= frame_ok_d;
            osd_en_lat_q <= osd_en_lat_d;
            text_addr_q  <= text_addr_d;
            rom_addr_q   <= rom_addr_d;
            rom_rd_en_q  <= 1'b1;
            s1_q         <= s0;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            s4_q         <= s3_q;
            vs_out_q     <= s4_q.vs;
            hs_out_q     <= s4_q.hs;
            de_out_q     <= s4_q.de;
            pix_out_q    <= pix_out_d;
        end
    end

    assign osd_io.text_addr = text_addr_q;
    assign osd_io.rom_addr  = rom_addr_q;
    assign osd_io.rom_rd_en = rom_rd_en_q;
    assign osd_io.vs_out    = vs_out_q;
    assign osd_io.hs_out    = hs_out_q;
    assign osd_io.de_out    = de_out_q;
    assign osd_io.pix_out   = pix_out_q;

endmodule

// File: tb/tb_osd_char_render.sv
// Directed bench for osd_char_render: default DUT plus a BG_EN=1 DUT fed the same video,
// 64-pixel lines, 37 lines per frame, text buffer of 'A' with a few special cells.
module tb_osd_char_render;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    osd_char_render_if #(.PIX_W(24), .TEXT_AW(5), .ROM_AW(11)) ifa ();
    osd_char_render_if #(.PIX_W(24), .TEXT_AW(5), .ROM_AW(11)) ifb ();

    osd_char_render u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .osd_io (ifa.slave)
    );

    osd_char_render #(
        .BG_EN    (1'b1),
        .BG_COLOR (24'h000080)
    ) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .osd_io (ifb.slave)
    );

    assign ifb.osd_en = ifa.osd_en;
    assign ifb.vs_in  = ifa.vs_in;
    assign ifb.hs_in  = ifa.hs_in;
    assign ifb.de_in  = ifa.de_in;
    assign ifb.pix_in = ifa.pix_in;

    logic [7:0] tbuf [32];

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        case (a)
            11'h410: rom_fn = 8'h18;
            11'h413: rom_fn = 8'h24;
            11'h423: rom_fn = 8'h81;
            default: rom_fn = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        ifa.text_data <= tbuf[ifa.text_addr];
        ifb.text_data <= tbuf[ifb.text_addr];
        if (ifa.rom_rd_en) ifa.rom_data <= rom_fn(ifa.rom_addr);
        if (ifb.rom_rd_en) ifb.rom_data <= rom_fn(ifb.rom_addr);
    end

    int checks = 0;
    int errors = 0;
    int n = 0;
    int sync_from = 1 << 30;
    int cap_x = 0;
    int probe = -100;
    bit chk_pix = 1'b0;
    logic [26:0] hist [8];
    logic [23:0] cap_a [64];
    logic [23:0] cap_b [64];
    logic [23:0] s15_a [64];
    logic [23:0] s16_a [64];
    logic [23:0] s16_b [64];
    logic [23:0] s35_a [64];
    logic [23:0] s35_b [64];
    logic [4:0]  ta_p1;
    logic [10:0] ra_p2, ra_p3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: log inputs, advance, then check outputs against inputs from 5 clocks back.
    task automatic tick();
        logic [26:0] h;
        hist[3'(n)] = {ifa.vs_in, ifa.hs_in, ifa.de_in, ifa.pix_in};
        @(posedge clk);
        #1;
        n++;
        if (n - 5 >= sync_from) begin
            h = hist[3'(n - 5)];
            check("sync_lag", 32'({ifa.vs_out, ifa.hs_out, ifa.de_out}), 32'(h[26:24]));
            if (chk_pix) begin
                check("pass_a", 32'(ifa.pix_out), 32'(h[23:0]));
                check("pass_b", 32'(ifb.pix_out), 32'(h[23:0]));
            end
        end else begin
            check("flushed", 32'({ifa.vs_out, ifa.hs_out, ifa.de_out, ifa.pix_out}), 32'd0);
        end
        if (ifa.de_out) begin
            cap_a[6'(cap_x)] = ifa.pix_out;
            cap_b[6'(cap_x)] = ifb.pix_out;
            cap_x++;
        end else begin
            cap_x = 0;
        end
        if (n == probe + 1) ta_p1 = ifa.text_addr;
        if (n == probe + 2) ra_p2 = ifa.rom_addr;
        if (n == probe + 3) ra_p3 = ifa.rom_addr;
    endtask

    task automatic do_line(input int l, input int rst_at);
        for (int x = 0; x < 64; x++) begin
            if (x == rst_at) begin
                rst = 1'b1;
                sync_from = 1 << 30;
                #1;
                check("rst_async_out",
                      32'({ifa.vs_out, ifa.hs_out, ifa.de_out, ifa.pix_out}), 32'd0);
                check("rst_async_addr",
                      32'({ifa.text_addr, ifa.rom_addr, ifa.rom_rd_en}), 32'd0);
                tick();
                tick();
                rst = 1'b0;
                sync_from = n;
                chk_pix = 1'b1;
            end
            ifa.de_in  = 1'b1;
            ifa.pix_in = {4'h5, 8'(l), 12'(x)};
            if (l == 35 && x == 56) probe = n;
            tick();
        end
        ifa.de_in  = 1'b0;
        ifa.pix_in = 24'h0;
        for (int b = 0; b < 8; b++) begin
            ifa.hs_in = (b >= 2 && b < 5);
            tick();
        end
        ifa.hs_in = 1'b0;
    endtask

    task automatic vsync();
        ifa.vs_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ifa.vs_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic do_frame(input bit with_vs, input int rst_line, input int drop_line);
        if (with_vs) vsync();
        for (int l = 0; l < 37; l++) begin
            do_line(l, (l == rst_line) ? 30 : -1);
            if (l == drop_line) ifa.osd_en = 1'b0;
            if (l == 15) s15_a = cap_a;
            if (l == 16) begin
                s16_a = cap_a;
                s16_b = cap_b;
            end
            if (l == 35) begin
                s35_a = cap_a;
                s35_b = cap_b;
            end
        end
    endtask

    initial begin
        ifa.osd_en = 1'b1;
        ifa.vs_in  = 1'b0;
        ifa.hs_in  = 1'b0;
        ifa.de_in  = 1'b0;
        ifa.pix_in = 24'h0;
        for (int i = 0; i < 32; i++) tbuf[i] = 8'h41;
        tbuf[2]  = 8'hC1;
        tbuf[21] = 8'h42;

        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_text_addr", 32'(ifa.text_addr), 32'd0);
        check("rst_rom_addr", 32'(ifa.rom_addr), 32'd0);
        check("rst_rom_rd_en", 32'(ifa.rom_rd_en), 32'd0);
        rst = 1'b0;
        sync_from = n;
        tick();
        check("rom_rd_en_on", 32'(ifa.rom_rd_en), 32'd1);

        // Before any vs rise the overlay is suppressed even inside the window.
        chk_pix = 1'b1;
        do_frame(1'b0, -1, -1);
        check("prevs_l16_x19", 32'(s16_a[19]), 32'h510013);
        chk_pix = 1'b0;

        // Frame 1: overlay on.
        do_frame(1'b1, -1, -1);
        check("f1_l15_x19", 32'(s15_a[19]), 32'h50F013);
        check("f1_l16_x16", 32'(s16_a[16]), 32'h510010);
        check("f1_l16_x18", 32'(s16_a[18]), 32'h510012);
        check("f1_l16_x19", 32'(s16_a[19]), 32'hFFFFFF);
        check("f1_l16_x20", 32'(s16_a[20]), 32'hFFFFFF);
        check("f1_l16_x21", 32'(s16_a[21]), 32'h510015);
        check("f1_c1_x34", 32'(s16_a[34]), 32'h510022);
        check("f1_c1_x35", 32'(s16_a[35]), 32'hFFFFFF);
        check("f1_c1_x36", 32'(s16_a[36]), 32'hFFFFFF);
        check("f1_b_x15", 32'(s16_b[15]), 32'h51000F);
        check("f1_b_x16", 32'(s16_b[16]), 32'h000080);
        check("f1_b_x19", 32'(s16_b[19]), 32'hFFFFFF);
        check("f1_b_x8", 32'(s16_b[8]), 32'h510008);
        check("f1_l35_x50", 32'(s35_a[50]), 32'hFFFFFF);
        check("f1_l35_x51", 32'(s35_a[51]), 32'h523033);
        check("f1_l35_x56", 32'(s35_a[56]), 32'hFFFFFF);
        check("f1_l35_x57", 32'(s35_a[57]), 32'h523039);
        check("f1_l35_x63", 32'(s35_a[63]), 32'hFFFFFF);
        check("f1_b_l35_x57", 32'(s35_b[57]), 32'h000080);
        check("text_addr_x56", 32'(ta_p1), 32'd21);
        check("rom_addr_x55", 32'(ra_p2), 32'h413);
        check("rom_addr_x56", 32'(ra_p3), 32'h423);

        // Frame 2: osd_en dropped after line 10 stays effective for this frame.
        do_frame(1'b1, -1, 10);
        check("f2_l16_x19", 32'(s16_a[19]), 32'hFFFFFF);
        check("f2_l16_x20", 32'(s16_a[20]), 32'hFFFFFF);

        // Frame 3: osd_en latched low, plain pass-through.
        chk_pix = 1'b1;
        do_frame(1'b1, -1, -1);
        check("f3_l16_x19", 32'(s16_a[19]), 32'h510013);
        check("f3_b_l16_x16", 32'(s16_b[16]), 32'h510010);
        chk_pix = 1'b0;

        // Frame 4: reset mid-line 16; video passes unmodified until the next vs rise.
        ifa.osd_en = 1'b1;
        do_frame(1'b1, 16, -1);
        check("f4_l35_x50", 32'(s35_a[50]), 32'h523032);
        chk_pix = 1'b0;

        // Frame 5: overlay restored.
        do_frame(1'b1, -1, -1);
        check("f5_l16_x16", 32'(s16_a[16]), 32'h510010);
        check("f5_l16_x19", 32'(s16_a[19]), 32'hFFFFFF);
        check("f5_l35_x56", 32'(s35_a[56]), 32'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_char_render.md
Name: osd_char_render

Overview:
- Text-overlay renderer for the UDP OSD path. It sits directly upstream of the ASCII character ROM.
- It walks the incoming video raster and works out which on-screen text cell each pixel falls in.
- It fetches that cell's character code from a text buffer, forms the glyph-row address into the character ROM, and takes the returned glyph bits.
- It muxes a foreground (and optional background) colour over the passing video. Timing is fully pipelined.

Parameters:
- PIX_W, 24, pixel data width (RGB888).
- H_START, 16, window left edge, in active-pixel units.
- V_START, 16, window top edge, in active-line units.
- COLS, 16, text cells per row (power of two, 2..64).
- ROWS, 2, text rows (power of two, 1..16).
- TEXT_AW, 5, text buffer address width; must equal log2(COLS*ROWS).
- ROM_AW, 11, character ROM address width: 7-bit code plus 4-bit glyph row.
- FG_COLOR, 24'hFFFFFF, colour of set glyph bits.
- BG_EN, 0, 1 = fill unset glyph bits inside the window with BG_COLOR; 0 = pass video through.
- BG_COLOR, 24'h000000, background fill colour.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-high reset.
- osd_en, in, 1, overlay enable; sampled at frame start.
- vs_in, in, 1, vertical sync, active-high.
- hs_in, in, 1, horizontal sync, active-high.
- de_in, in, 1, active-video data enable.
- pix_in, in, PIX_W, input pixel.
- text_addr, out, TEXT_AW, text buffer read address; equals crow*COLS+col.
- text_data, in, 8, character code from the text buffer; synchronous, 1-cycle read latency.
- rom_addr, out, ROM_AW, character ROM address: {code[6:0], glyph_row[3:0]}.
- rom_rd_en, out, 1, ROM clock enable; high whenever not in reset.
- rom_data, in, 8, glyph row from the ROM; 1-cycle latency, no output register; bit 7 is the leftmost pixel.
- vs_out, out, 1, delayed vs_in.
- hs_out, out, 1, delayed hs_in.
- de_out, out, 1, delayed de_in.
- pix_out, out, PIX_W, composited pixel.

Behaviour:
- Character cell is 8x16 pixels. Window size is COLS*8 by ROWS*16.
- Raster counters:
  - x_cnt (12 bit) increments on each de_in=1 cycle and clears on the first cycle with de_in=0.
  - y_cnt (11 bit) increments on each de_in falling edge and clears on the vs_in rising edge.
  - Both counters saturate at all-ones; they do not wrap.
- Window hit: in_win = de_in & (x_cnt-H_START) < COLS*8 & (y_cnt-V_START) < ROWS*16, with unsigned compares after the start check.
- Derived cell fields: col = (x_cnt-H_START)>>3, bit_idx = (x_cnt-H_START)[2:0], crow = (y_cnt-V_START)>>4, glyph_row = (y_cnt-V_START)[3:0].
- Pipeline, for an input pixel presented in cycle k:
  - Edge k+1: text_addr registered; side-band fields registered.
  - Edge k+2: text_data is returned.
  - Edge k+3: rom_addr registered from text_data[6:0]; text_data[7] is ignored.
  - Edge k+4: rom_data is returned.
  - Edge k+5: pix_out and the sync/de outputs are registered.
- Fixed latency: vs_out, hs_out, de_out and pix_out equal their inputs delayed by exactly 5 clocks. The delay is identical in and out of the window.
- Pixel mux at output, when active=1 and in_win is delayed:
  - rom_data[7-bit_idx]=1 gives FG_COLOR.
  - Otherwise BG_COLOR if BG_EN=1, else pix_in delayed.
  - Outside the window, or when active=0, pix_out equals pix_in delayed.
- Outside the window, text_addr and rom_addr hold their last value; no toggling is required.
- Frame control:
  - frame_ok clears on reset and sets on the first vs_in rising edge after reset.
  - active = frame_ok & osd_en_latched. osd_en_latched samples osd_en on each vs_in rising edge, so osd_en changes mid-frame take effect next frame with no tearing.
- Reset state:
  - vs_out, hs_out, de_out and pix_out are 0; text_addr and rom_addr are 0.
  - rom_rd_en is 0 during reset and 1 from the first clock after release.
  - Counters, pipeline registers, frame_ok and osd_en_latched are all 0.
- Reset mid-frame: the pipeline flushes to zeros. The output stream resumes 5 clocks after the first post-reset input. The overlay stays suppressed until the next vs_in rise.
- Simultaneous vs_in rise and de_in falling edge: the clear takes priority over the increment.
- Window partly beyond the active area: cells past the line end are simply never reached. No error is raised.

Test Plan:
- Defaults, text buffer all 0x41, ROM row 0 of 'A' = 8'h18: line V_START, pixels x=19,20 → FG_COLOR 24'hFFFFFF; pixel x=16 → pix_in unchanged; all outputs lag inputs by 5 clocks.
- Addressing: pixel (x=16+8*5, y=16+16*1+3) → text_addr=21; code 0x42 → rom_addr=0x423.
- BG_EN=1, BG_COLOR=24'h000080: unset glyph bits inside the window → 24'h000080; pixels outside the window unchanged.
- osd_en dropped mid-frame: overlay stays on for the rest of the frame and is off from the next vs_in rise; the 5-clock latency is unchanged.
- rst asserted mid-line: all outputs 0 immediately (async); after release the video passes through unmodified until vs_in rises; the following frame overlays correctly.
- Code 0xC1: renders identical to 0x41 because bit 7 is ignored.
